// File: rtl/led_pwm_driver.sv
// led_pwm_driver
// Brightness and blink stage between the custom_led register block and the
// board LED pins. Every lit LED is pulse-width modulated at one global duty,
// with optional blinking and output inversion. Configuration is through a
// small 2-bit Avalon-MM slave with its own chip-select.
//
// Bus handshake: there is no ready/waitrequest. A transfer happens on every
// rising clk edge where chipselect is high together with read or write. A
// write updates the addressed register on that edge. A read captures the
// addressed register into readdata on that edge, so the data is valid in the
// following cycle. When read and write hit together, readdata captures the
// value from before the write.
module led_pwm_driver #(
    parameter int NUM_LEDS = 10,
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          address,
    input  logic                chipselect,
    input  logic                read,
    input  logic                write,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    input  logic [NUM_LEDS-1:0] led_in,
    output logic [NUM_LEDS-1:0] led_pwm
);

    // Register map
    localparam logic [1:0] ADDR_CTRL     = 2'd0;
    localparam logic [1:0] ADDR_DUTY     = 2'd1;
    localparam logic [1:0] ADDR_PRESCALE = 2'd2;
    localparam logic [1:0] ADDR_BLINK    = 2'd3;

    // DUTY comes out of reset at half brightness
    localparam logic [PWM_BITS-1:0] DUTY_RESET = PWM_BITS'(8'h80);

    // Last count value of the PWM counter; its wrap marks a frame start
    localparam logic [PWM_BITS-1:0] PWM_MAX = {PWM_BITS{1'b1}};

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    logic                ctrl_enable;
    logic                ctrl_blink_en;
    logic                ctrl_invert;
    logic [PWM_BITS-1:0] duty_reg;
    logic [15:0]         prescale_reg;
    logic [15:0]         blink_reg;

    // ------------------------------------------------------------------
    // Datapath state
    // ------------------------------------------------------------------
    logic [15:0]         pre_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty_act;
    logic [15:0]         blink_cnt;
    logic                blink_phase;

    // ------------------------------------------------------------------
    // Decoded bus strobes and internal events
    // ------------------------------------------------------------------
    logic                wr_en;
    logic                rd_en;
    logic                wr_ctrl;
    logic                wr_duty;
    logic                wr_prescale;
    logic                wr_blink;
    logic [31:0]         rd_value;
    logic                tick;
    logic                frame_wrap;
    logic                blink_wrap;
    logic                pwm_on;
    logic                blink_gate;
    logic [NUM_LEDS-1:0] led_next;

    // Upper write-data bits have no register behind them
    logic                unused_wdata;

    assign unused_wdata = ^writedata[31:16];

    // Bus strobe decode: one register select per address
    always_comb begin
        wr_en       = chipselect & write;
        rd_en       = chipselect & read;
        wr_ctrl     = 1'b0;
        wr_duty     = 1'b0;
        wr_prescale = 1'b0;
        wr_blink    = 1'b0;
        if (wr_en) begin
            case (address)
                ADDR_CTRL:     wr_ctrl     = 1'b1;
                ADDR_DUTY:     wr_duty     = 1'b1;
                ADDR_PRESCALE: wr_prescale = 1'b1;
                ADDR_BLINK:    wr_blink    = 1'b1;
                default:       wr_ctrl     = 1'b0;
            endcase
        end
    end

    // Configuration register writes; bits outside each field are dropped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_enable   <= 1'b0;
            ctrl_blink_en <= 1'b0;
            ctrl_invert   <= 1'b0;
            duty_reg      <= DUTY_RESET;
            prescale_reg  <= 16'd0;
            blink_reg     <= 16'd0;
        end else begin
            if (wr_ctrl) begin
                ctrl_enable   <= writedata[0];
                ctrl_blink_en <= writedata[1];
                ctrl_invert   <= writedata[2];
            end
            if (wr_duty) begin
                duty_reg <= writedata[PWM_BITS-1:0];
            end
            if (wr_prescale) begin
                prescale_reg <= writedata[15:0];
            end
            if (wr_blink) begin
                blink_reg <= writedata[15:0];
            end
        end
    end

    // Read mux: unimplemented bits read as zero
    always_comb begin
        rd_value = 32'd0;
        case (address)
            ADDR_CTRL:     rd_value = {29'd0, ctrl_invert, ctrl_blink_en, ctrl_enable};
            ADDR_DUTY:     rd_value = {{(32-PWM_BITS){1'b0}}, duty_reg};
            ADDR_PRESCALE: rd_value = {16'd0, prescale_reg};
            ADDR_BLINK:    rd_value = {16'd0, blink_reg};
            default:       rd_value = 32'd0;
        endcase
    end

    // Registered read data; holds its value between reads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= 32'd0;
        end else if (rd_en) begin
            readdata <= rd_value;
        end
    end

    // Event decode. A PRESCALE write restarts the prescaler without
    // advancing the PWM counter; a BLINK write restarts the frame count
    // without flipping the blink phase.
    always_comb begin
        tick       = ctrl_enable & ~wr_prescale & (pre_cnt == prescale_reg);
        frame_wrap = tick & (pwm_cnt == PWM_MAX);
        blink_wrap = frame_wrap & ~wr_blink & (blink_cnt == blink_reg);
    end

    // Prescaler: counts 0..PRESCALE, one tick per wrap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= 16'd0;
        end else if (!ctrl_enable || wr_prescale || tick) begin
            pre_cnt <= 16'd0;
        end else begin
            pre_cnt <= pre_cnt + 16'd1;
        end
    end

    // PWM counter: advances once per tick and wraps at the end of a frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt <= '0;
        end else if (!ctrl_enable) begin
            pwm_cnt <= '0;
        end else if (tick) begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Duty shadow: follows DUTY while idle, otherwise only at frame start,
    // so a mid-frame DUTY write never glitches the running frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_act <= DUTY_RESET;
        end else if (!ctrl_enable || frame_wrap) begin
            duty_act <= duty_reg;
        end
    end

    // Blink frame counter: counts frames 0..BLINK
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt <= 16'd0;
        end else if (!ctrl_enable || wr_blink) begin
            blink_cnt <= 16'd0;
        end else if (frame_wrap) begin
            if (blink_cnt == blink_reg) begin
                blink_cnt <= 16'd0;
            end else begin
                blink_cnt <= blink_cnt + 16'd1;
            end
        end
    end

    // Blink phase: starts in the visible phase and flips on each blink wrap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_phase <= 1'b1;
        end else if (!ctrl_enable) begin
            blink_phase <= 1'b1;
        end else if (blink_wrap) begin
            blink_phase <= ~blink_phase;
        end
    end

    // Per-LED drive: lit LEDs gated by PWM and blink, then optional inversion
    always_comb begin
        pwm_on     = (pwm_cnt < duty_act);
        blink_gate = ~ctrl_blink_en | blink_phase;
        led_next   = {NUM_LEDS{ctrl_invert}}
                   ^ (led_in & {NUM_LEDS{ctrl_enable & pwm_on & blink_gate}});
    end

    // Output register: one clock from led_in and config to the pins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_pwm <= '0;
        end else begin
            led_pwm <= led_next;
        end
    end

endmodule
